// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier for the MULT/MULTU path.
// Every addition and negation is performed by an rca_Nbit ripple-carry adder.
// Handshake: start (accepted only while idle), busy, and a one-cycle done pulse.
// hi/lo are written only in the FIX state and otherwise keep their value.

module rca_Nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    genvar i;
    for (i = 0; i < N; i++) begin : g_fa
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_rest
            assign ci = g_fa[i-1].co;
        end
        assign sum[i] = x[i] ^ y[i] ^ ci;
        assign co     = (x[i] & y[i]) | (ci & (x[i] ^ y[i]));
    end

    assign cout = g_fa[N-1].co;

endmodule

module seq_multiplier #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int               CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        MUL  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [N-1:0]     mcand_r;
    logic [N-1:0]     mplr_r;
    logic [N-1:0]     acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sgn_r;
    logic             neg_r;
    logic [N-1:0]     hi_r;
    logic [N-1:0]     lo_r;
    logic             busy_r;
    logic             done_r;

    logic [N-1:0]     nega_sum_s;
    logic             nega_cout_unused;
    logic [N-1:0]     negb_sum_s;
    logic             negb_cout_unused;
    logic [N-1:0]     addend_s;
    logic [N-1:0]     add_sum_s;
    logic             add_cout_s;
    logic [N-1:0]     fixlo_sum_s;
    logic             fixlo_cout_s;
    logic [N-1:0]     fixhi_sum_s;
    logic             fixhi_cout_unused;

    // Magnitude of the multiplicand: ~a + 1 (used only when it is negative).
    rca_Nbit #(.N(N)) u_neg_a (
        .x(~mcand_r), .y({N{1'b0}}), .cin(1'b1), .sum(nega_sum_s), .cout(nega_cout_unused)
    );

    // Magnitude of the multiplier: ~b + 1 (used only when it is negative).
    rca_Nbit #(.N(N)) u_neg_b (
        .x(~mplr_r), .y({N{1'b0}}), .cin(1'b1), .sum(negb_sum_s), .cout(negb_cout_unused)
    );

    assign addend_s = mplr_r[0] ? mcand_r : {N{1'b0}};

    // Partial-product accumulation; the carry becomes the new top bit on the shift.
    rca_Nbit #(.N(N)) u_add (
        .x(acc_r), .y(addend_s), .cin(1'b0), .sum(add_sum_s), .cout(add_cout_s)
    );

    // 2N-bit negate, low half: ~lo + 1, carry continues into the high half.
    rca_Nbit #(.N(N)) u_fix_lo (
        .x(~mplr_r), .y({N{1'b0}}), .cin(1'b1), .sum(fixlo_sum_s), .cout(fixlo_cout_s)
    );

    // 2N-bit negate, high half: ~hi + carry out of the low half.
    rca_Nbit #(.N(N)) u_fix_hi (
        .x(~acc_r), .y({N{1'b0}}), .cin(fixlo_cout_s), .sum(fixhi_sum_s), .cout(fixhi_cout_unused)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> PREP -> MUL x N -> FIX -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = PREP;
                end else begin
                    state_s = IDLE;
                end
            end
            PREP: state_s = MUL;
            MUL: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = MUL;
                end
            end
            FIX:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Registered handshake outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
        end
    end

    // Datapath: operand capture, sign handling, shift-and-add, final sign fix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= {N{1'b0}};
            mplr_r  <= {N{1'b0}};
            acc_r   <= {N{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sgn_r   <= 1'b0;
            neg_r   <= 1'b0;
            hi_r    <= {N{1'b0}};
            lo_r    <= {N{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r <= a;
                        mplr_r  <= b;
                        sgn_r   <= is_signed;
                    end else begin
                        mcand_r <= mcand_r;
                    end
                end
                PREP: begin
                    // 0x80..0 negates to itself, which is the correct unsigned magnitude.
                    if (sgn_r && mcand_r[N-1]) begin
                        mcand_r <= nega_sum_s;
                    end else begin
                        mcand_r <= mcand_r;
                    end
                    if (sgn_r && mplr_r[N-1]) begin
                        mplr_r <= negb_sum_s;
                    end else begin
                        mplr_r <= mplr_r;
                    end
                    neg_r <= sgn_r & (mcand_r[N-1] ^ mplr_r[N-1]);
                    acc_r <= {N{1'b0}};
                    cnt_r <= {CNT_W{1'b0}};
                end
                MUL: begin
                    acc_r  <= {add_cout_s, add_sum_s[N-1:1]};
                    mplr_r <= {add_sum_s[0], mplr_r[N-1:1]};
                    cnt_r  <= cnt_r + CNT_ONE;
                end
                FIX: begin
                    if (neg_r) begin
                        hi_r <= fixhi_sum_s;
                        lo_r <= fixlo_sum_s;
                    end else begin
                        hi_r <= acc_r;
                        lo_r <= mplr_r;
                    end
                end
                DONE: begin
                    hi_r <= hi_r;
                end
                default: begin
                    hi_r <= hi_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (N=32): the driver pushes hand-computed
// products, a separate monitor pops and compares on every done pulse.

module tb_seq_multiplier;

    localparam int N   = 32;
    localparam int LAT = N + 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        int           t0;
        string        name;
    } exp_t;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    seq_multiplier #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                n_checks++;
                if (scb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d with no request pending", cyc);
                end else begin
                    e = scb.pop_front();
                    check({e.name, "_product"}, {hi, lo}, {e.hi, e.lo});
                    check({e.name, "_latency"}, 64'(cyc - e.t0), 64'(LAT));
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy=%b after 200 cycles, expected 0", nm, busy);
        end
    endtask

    task automatic issue(input logic s, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] eh, input logic [N-1:0] el, input string nm);
        wait_idle(nm);
        start     = 1'b1;
        is_signed = s;
        a         = x;
        b         = y;
        scb.push_back('{eh, el, cyc, nm});
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int k;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        #1;
        check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed products.
        issue(1'b0, 32'd3,          32'd5,          32'h00000000, 32'h0000000F, "multu_3x5");
        issue(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, "multu_max");
        issue(1'b1, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5");
        issue(1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001, "mult_m1xm1");
        issue(1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000, "mult_min_min");
        issue(1'b1, 32'h00000000,   32'h80000000,   32'h00000000, 32'h00000000, "mult_0xmin");
        issue(1'b1, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h80000001, "mult_max_m1");
        issue(1'b0, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000, "multu_min_x2");
        issue(1'b0, 32'h12345678,   32'h00000010,   32'h00000001, 32'h23456780, "multu_shift");
        wait_idle("drain");
        repeat (3) @(negedge clk);
        check("hold_after_done", {hi, lo}, {32'h00000001, 32'h23456780});

        // Starts during MUL and during DONE must be ignored.
        d0 = done_cnt;
        issue(1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "ignore_start");
        repeat (5) @(negedge clk);
        start = 1'b1; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        start = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (45) @(negedge clk);
        check("single_done_pulse", 64'(done_cnt - d0), 64'd1);
        check("idle_after_ignore", {63'd0, busy}, 64'd0);
        check("result_stable", {hi, lo}, {32'h00000001, 32'h00000000});

        // Reset in the middle of MUL aborts the operation.
        issue(1'b0, 32'h00001234, 32'h00000010, 32'h00000000, 32'h00012340, "aborted");
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        scb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        issue(1'b0, 32'd7, 32'd6, 32'h00000000, 32'h0000002A, "after_reset_7x6");
        wait_idle("after_reset");
        repeat (2) @(negedge clk);
        check("after_reset_done_count", 64'(done_cnt - d0), 64'd1);
        check("scoreboard_empty", 64'(scb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
